// File: rtl/snn_pkg.sv
// Shared types and helpers for the TMR LIF neuron scheduler.
package snn_pkg;

    localparam int unsigned Q_W       = 16;  // Q8.8 word width
    localparam int unsigned FRAC_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCompute,
        StWrite,
        StEmit,
        StDone
    } state_t;

    // Clamp a wide signed intermediate into the signed 16-bit range.
    function automatic logic [Q_W-1:0] sat16(input logic signed [32:0] x);
        if (x > 33'sd32767) begin
            return 16'h7fff;
        end else if (x < -33'sd32768) begin
            return 16'h8000;
        end else begin
            return x[Q_W-1:0];
        end
    endfunction

    // Bitwise 2-of-3 majority vote.
    function automatic logic [Q_W-1:0] maj3(input logic [Q_W-1:0] a,
                                            input logic [Q_W-1:0] b,
                                            input logic [Q_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_lif_scheduler_if.sv
// Control, current-fetch, spike-event and fault-injection signals of the scheduler.
interface tmr_lif_scheduler_if #(
    parameter int unsigned IDXW = 3
);
    logic            start;
    logic [15:0]     dt_tau;
    logic            busy;
    logic            done;
    logic            cur_req;
    logic [IDXW-1:0] cur_idx;
    logic [15:0]     cur_data;
    logic            cur_valid;
    logic            spk_valid;
    logic [IDXW-1:0] spk_idx;
    logic            spk_ready;
    logic [15:0]     fault_cnt;
    logic            inj_en;
    logic [1:0]      inj_sel;
    logic [IDXW-1:0] inj_idx;
    logic [15:0]     inj_val;

    modport master (
        output start, dt_tau, cur_data, cur_valid, spk_ready,
               inj_en, inj_sel, inj_idx, inj_val,
        input  busy, done, cur_req, cur_idx, spk_valid, spk_idx, fault_cnt
    );

    modport slave (
        input  start, dt_tau, cur_data, cur_valid, spk_ready,
               inj_en, inj_sel, inj_idx, inj_val,
        output busy, done, cur_req, cur_idx, spk_valid, spk_idx, fault_cnt
    );
endinterface

// File: rtl/lif_replica_update.sv
// Combinational leaky-integrate update of one membrane-potential replica.
module lif_replica_update
    import snn_pkg::*;
(
    input  logic [Q_W-1:0] v,
    input  logic [Q_W-1:0] cur,
    input  logic [Q_W-1:0] dt_tau,
    output logic [Q_W-1:0] v_next
);
    logic signed [16:0] diff;
    logic signed [32:0] prod;
    logic signed [32:0] sum;

    // V' = sat16(V + (((I - V) * dt_tau) >>> 8)) with full-width intermediates.
    always_comb begin
        diff   = $signed({cur[15], cur}) - $signed({v[15], v});
        prod   = $signed({{16{diff[16]}}, diff}) * $signed({{17{dt_tau[15]}}, dt_tau});
        sum    = $signed({{17{v[15]}}, v}) + (prod >>> FRAC_BITS);
        v_next = sat16(sum);
    end
endmodule

// File: rtl/tmr_lif_scheduler.sv
// Time-multiplexed scheduler stepping N TMR-protected LIF neurons once per timestep.
module tmr_lif_scheduler
    import snn_pkg::*;
#(
    parameter int unsigned N_NEURONS = 8,
    parameter logic [15:0] V_TH      = 16'h3000,
    parameter logic [15:0] V_RESET   = 16'h0000
) (
    input logic                clk,
    input logic                rst,
    tmr_lif_scheduler_if.slave bus
);
    localparam int unsigned     IDXW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N_NEURONS - 1);

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic [Q_W-1:0]  dt_q, cur_q, vv_q;
    logic            spike_q, mism_q;
    logic            busy_q, done_q, cur_req_q, spk_valid_q;
    logic [IDXW-1:0] cur_idx_q, spk_idx_q;
    logic [15:0]     fault_cnt_q;
    logic [Q_W-1:0]  rep_q [3][N_NEURONS];

    logic [Q_W-1:0]  v_next [3];
    logic [Q_W-1:0]  vv;
    logic            mism, spike, advance;

    for (genvar r = 0; r < 3; r++) begin : g_rep
        lif_replica_update u_upd (
            .v      (rep_q[r][idx_q]),
            .cur    (cur_q),
            .dt_tau (dt_q),
            .v_next (v_next[r])
        );
    end

    // Vote the three replica results and derive spike/mismatch flags.
    always_comb begin
        vv      = maj3(v_next[0], v_next[1], v_next[2]);
        mism    = (v_next[0] != vv) || (v_next[1] != vv) || (v_next[2] != vv);
        spike   = $signed(vv) >= $signed(V_TH);
        // Leave the current neuron: after a non-spiking WRITE or an accepted spike event.
        advance = ((state_q == StWrite) && !spike_q) || ((state_q == StEmit) && bus.spk_ready);
    end

    // Scheduler FSM, replica storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            dt_q        <= '0;
            cur_q       <= '0;
            vv_q        <= '0;
            spike_q     <= 1'b0;
            mism_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cur_req_q   <= 1'b0;
            cur_idx_q   <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            fault_cnt_q <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int n = 0; n < int'(N_NEURONS); n++) begin
                    rep_q[r][n] <= V_RESET;
                end
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Injection shares the start edge; COMPUTE reads the replicas later.
                    if (bus.inj_en && (bus.inj_sel != 2'd3)) begin
                        rep_q[bus.inj_sel][bus.inj_idx] <= bus.inj_val;
                    end
                    if (bus.start) begin
                        dt_q      <= bus.dt_tau;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        cur_req_q <= 1'b1;
                        cur_idx_q <= '0;
                        state_q   <= StFetch;
                    end
                end
                StFetch: begin
                    if (bus.cur_valid) begin
                        cur_q     <= bus.cur_data;
                        cur_req_q <= 1'b0;
                        state_q   <= StCompute;
                    end
                end
                StCompute: begin
                    vv_q    <= vv;
                    spike_q <= spike;
                    mism_q  <= mism;
                    state_q <= StWrite;
                end
                StWrite: begin
                    for (int r = 0; r < 3; r++) begin
                        rep_q[r][idx_q] <= spike_q ? V_RESET : vv_q;
                    end
                    if (mism_q && (fault_cnt_q != 16'hffff)) begin
                        fault_cnt_q <= fault_cnt_q + 16'd1;
                    end
                    if (spike_q) begin
                        spk_valid_q <= 1'b1;
                        spk_idx_q   <= idx_q;
                        state_q     <= StEmit;
                    end
                end
                StEmit: begin
                    if (bus.spk_ready) begin
                        spk_valid_q <= 1'b0;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (advance) begin
                if (idx_q == LAST) begin
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end else begin
                    idx_q     <= idx_q + IDXW'(1);
                    cur_req_q <= 1'b1;
                    cur_idx_q <= idx_q + IDXW'(1);
                    state_q   <= StFetch;
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cur_req   = cur_req_q;
    assign bus.cur_idx   = cur_idx_q;
    assign bus.spk_valid = spk_valid_q;
    assign bus.spk_idx   = spk_idx_q;
    assign bus.fault_cnt = fault_cnt_q;
endmodule

// File: tb/tb_tmr_lif_scheduler.sv
// Self-checking bench: table of timesteps, behavioural neuron model and spike scoreboard.
module tb_tmr_lif_scheduler;
    import snn_pkg::*;

    localparam int unsigned N    = 8;
    localparam int unsigned IDXW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tmr_lif_scheduler_if #(.IDXW(IDXW)) bus ();

    tmr_lif_scheduler #(
        .N_NEURONS (N),
        .V_TH      (16'h3000),
        .V_RESET   (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] cur_tab [N];
    always_comb bus.cur_data = cur_tab[bus.cur_idx];

    typedef struct {
        bit          rst_b;
        logic [15:0] dt;
        logic [15:0] all_val;
        int          sel_idx;
        logic [15:0] sel_val;
        bit          inj_en;
        logic [1:0]  inj_sel;
        logic [2:0]  inj_idx;
        logic [15:0] inj_val;
        int          spk_hold;
        int          fetch_hold;
        int          delay_idx;
        bit          restart;
        int          chk_idx;
        logic [15:0] exp_v;
        int          exp_fault;
        int          exp_spikes;
    } vec_t;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model state
    logic [15:0] m_rep [3][N];
    logic [15:0] m_dt;
    int          m_fault;
    int          m_spk;
    int          nxt_fetch;
    int          exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [15:0] ref_upd(input logic [15:0] v, input logic [15:0] i,
                                           input logic [15:0] dt);
        longint d, p, s;
        d = longint'($signed(i)) - longint'($signed(v));
        p = d * longint'($signed(dt));
        s = longint'($signed(v)) + (p >>> 8);
        if (s > 32767) return 16'h7fff;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 3; r++)
            for (int n = 0; n < N; n++) m_rep[r][n] = 16'h0000;
        m_fault = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input int n, input logic [15:0] i);
        logic [15:0] nv [3];
        logic [15:0] vv;
        bit mism;
        for (int r = 0; r < 3; r++) nv[r] = ref_upd(m_rep[r][n], i, m_dt);
        for (int b = 0; b < 16; b++) begin
            int ones;
            ones  = int'(nv[0][b]) + int'(nv[1][b]) + int'(nv[2][b]);
            vv[b] = (ones >= 2);
        end
        mism = (nv[0] !== vv) || (nv[1] !== vv) || (nv[2] !== vv);
        if (mism && m_fault < 65535) m_fault++;
        if ($signed(vv) >= $signed(16'h3000)) begin
            vv = 16'h0000;
            exp_q.push_back(n);
            m_spk++;
        end
        for (int r = 0; r < 3; r++) m_rep[r][n] = vv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_state(input string tag);
        int bad;
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_cur_req"}, 32'(bus.cur_req), 0);
        chk({tag, "_cur_idx"}, 32'(bus.cur_idx), 0);
        chk({tag, "_spk_valid"}, 32'(bus.spk_valid), 0);
        chk({tag, "_spk_idx"}, 32'(bus.spk_idx), 0);
        chk({tag, "_fault_cnt"}, 32'(bus.fault_cnt), 0);
        bad = 0;
        for (int r = 0; r < 3; r++)
            for (int n = 0; n < N; n++)
                if (dut.rep_q[r][n] !== 16'h0000) bad++;
        chk({tag, "_replicas_nonreset"}, 32'(bad), 0);
    endtask

    task automatic run_step(input int id, input vec_t v);
        int cyc, spk_seen, spk_wait, fetch_wait, exp_cyc, bad;
        bit finished;
        string tag;
        tag = $sformatf("v%0d", id);
        if (v.rst_b) do_reset();
        m_dt = v.dt;
        for (int n = 0; n < N; n++) cur_tab[n] = (n == v.sel_idx) ? v.sel_val : v.all_val;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.dt_tau  = v.dt;
        bus.inj_en  = v.inj_en;
        bus.inj_sel = v.inj_sel;
        bus.inj_idx = v.inj_idx;
        bus.inj_val = v.inj_val;
        if (v.inj_en && v.inj_sel != 2'd3) m_rep[v.inj_sel][v.inj_idx] = v.inj_val;
        @(posedge clk);
        cyc = 1; spk_seen = 0; spk_wait = 0; fetch_wait = 0; finished = 0;
        m_spk = 0; nxt_fetch = 0;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            bus.start  = 1'b0;
            bus.inj_en = 1'b0;
            // Start and injection while busy must both be ignored.
            if (v.restart && cyc == 6) begin
                bus.start   = 1'b1;
                bus.inj_en  = 1'b1;
                bus.inj_sel = 2'd0;
                bus.inj_idx = 3'd0;
                bus.inj_val = 16'h7777;
            end
            if (cyc == 2) chk({tag, "_busy"}, 32'(bus.busy), 1);
            if (bus.done) begin
                finished = 1;
            end else begin
                if (fetch_wait > 0 && fetch_wait < v.fetch_hold) begin
                    chk({tag, "_cur_req_hold"}, 32'(bus.cur_req), 1);
                    chk({tag, "_cur_idx_hold"}, 32'(bus.cur_idx), 32'(v.delay_idx));
                    bus.cur_valid = 1'b0;
                    fetch_wait++;
                end else if (bus.cur_req && int'(bus.cur_idx) == v.delay_idx &&
                             fetch_wait == 0 && v.fetch_hold > 0) begin
                    bus.cur_valid = 1'b0;
                    fetch_wait = 1;
                end else begin
                    bus.cur_valid = 1'b1;
                    if (bus.cur_req) begin
                        chk({tag, "_fetch_order"}, 32'(bus.cur_idx), 32'(nxt_fetch));
                        model_step(nxt_fetch, cur_tab[nxt_fetch]);
                        nxt_fetch++;
                    end
                end
                if (spk_wait > 0 && spk_wait < v.spk_hold) begin
                    chk({tag, "_spk_valid_hold"}, 32'(bus.spk_valid), 1);
                    chk({tag, "_spk_idx_hold"}, 32'(bus.spk_idx),
                        exp_q.size() > 0 ? 32'(exp_q[0]) : 32'hffff_ffff);
                    chk({tag, "_no_fetch_in_emit"}, 32'(bus.cur_req), 0);
                    bus.spk_ready = 1'b0;
                    spk_wait++;
                end else if (bus.spk_valid && spk_wait == 0 && v.spk_hold > 0) begin
                    bus.spk_ready = 1'b0;
                    spk_wait = 1;
                end else begin
                    bus.spk_ready = 1'b1;
                    if (bus.spk_valid) begin
                        if (exp_q.size() == 0) begin
                            chk({tag, "_spk_unexpected"}, 32'(bus.spk_idx), 32'hffff_ffff);
                        end else begin
                            chk({tag, "_spk_idx"}, 32'(bus.spk_idx), 32'(exp_q.pop_front()));
                        end
                        spk_seen++;
                        spk_wait = 0;
                    end
                end
            end
            if (!finished) begin
                @(posedge clk);
                cyc++;
            end
        end
        bus.cur_valid = 1'b1;
        bus.spk_ready = 1'b1;
        if (!finished) begin
            chk({tag, "_done_timeout"}, 0, 1);
        end else begin
            exp_cyc = 3 * N + 1 + m_spk * (1 + v.spk_hold) + v.fetch_hold;
            chk({tag, "_step_cycles"}, 32'(cyc), 32'(exp_cyc));
        end
        chk({tag, "_spike_count"}, 32'(spk_seen), 32'(v.exp_spikes));
        chk({tag, "_spikes_left"}, 32'(exp_q.size()), 0);
        chk({tag, "_fault_cnt_model"}, 32'(bus.fault_cnt), 32'(m_fault));
        chk({tag, "_fault_cnt"}, 32'(bus.fault_cnt), 32'(v.exp_fault));
        for (int r = 0; r < 3; r++)
            chk($sformatf("%s_rep%0d_n%0d", tag, r, v.chk_idx),
                32'(dut.rep_q[r][v.chk_idx]), 32'(v.exp_v));
        bad = 0;
        for (int r = 0; r < 3; r++)
            for (int n = 0; n < N; n++)
                if (dut.rep_q[r][n] !== m_rep[r][n]) bad++;
        chk({tag, "_replicas_vs_model"}, 32'(bad), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 0);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
        @(negedge clk);
        chk({tag, "_no_second_done"}, 32'(bus.done), 0);
    endtask

    function automatic vec_t mk(input bit rb, input logic [15:0] dt, input logic [15:0] allv,
                                input int si, input logic [15:0] sv, input bit ie,
                                input logic [1:0] isel, input logic [2:0] iidx,
                                input logic [15:0] ival, input int sh, input int fh,
                                input int di, input bit rs, input int ci,
                                input logic [15:0] ev, input int ef, input int es);
        vec_t v;
        v.rst_b = rb; v.dt = dt; v.all_val = allv; v.sel_idx = si; v.sel_val = sv;
        v.inj_en = ie; v.inj_sel = isel; v.inj_idx = iidx; v.inj_val = ival;
        v.spk_hold = sh; v.fetch_hold = fh; v.delay_idx = di; v.restart = rs;
        v.chk_idx = ci; v.exp_v = ev; v.exp_fault = ef; v.exp_spikes = es;
        return v;
    endfunction

    vec_t vecs [10];

    initial begin
        int waited;
        vecs[0] = mk(1, 16'h0100, 16'h1000, 8, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0,
                     7, 16'h1000, 0, 0);
        vecs[1] = mk(1, 16'h0100, 16'h0000, 3, 16'h3200, 0, 0, 0, 16'h0,    0, 0, 0, 0,
                     3, 16'h0000, 0, 1);
        vecs[2] = mk(1, 16'h0080, 16'h1000, 8, 16'h0,    1, 1, 2, 16'h0500, 0, 0, 0, 0,
                     2, 16'h0800, 1, 0);
        vecs[3] = mk(0, 16'h0080, 16'h1000, 8, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0,
                     2, 16'h0c00, 1, 0);
        vecs[4] = mk(1, 16'h0200, 16'h0000, 0, 16'h8000, 0, 0, 0, 16'h0,    0, 0, 0, 0,
                     0, 16'h8000, 0, 0);
        vecs[5] = mk(0, 16'h0100, 16'h3000, 8, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0,
                     0, 16'h0000, 0, 8);
        vecs[6] = mk(1, 16'h0100, 16'h2fff, 8, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0,
                     1, 16'h2fff, 0, 0);
        vecs[7] = mk(0, 16'h0080, 16'h0000, 8, 16'h0,    1, 0, 6, 16'h7fff, 0, 0, 0, 0,
                     6, 16'h17ff, 1, 0);
        vecs[8] = mk(0, 16'h0100, 16'h0100, 8, 16'h0,    1, 3, 6, 16'h7fff, 0, 0, 0, 0,
                     6, 16'h0100, 1, 0);
        vecs[9] = mk(1, 16'h0100, 16'h0000, 3, 16'h3200, 0, 0, 0, 16'h0,    5, 4, 5, 1,
                     3, 16'h0000, 0, 1);

        rst = 1'b1;
        bus.start = 1'b0; bus.dt_tau = '0; bus.cur_valid = 1'b1; bus.spk_ready = 1'b1;
        bus.inj_en = 1'b0; bus.inj_sel = '0; bus.inj_idx = '0; bus.inj_val = '0;
        for (int n = 0; n < N; n++) cur_tab[n] = 16'h0;
        do_reset();
        check_reset_state("reset");

        for (int k = 0; k < 10; k++) run_step(k, vecs[k]);

        // Reset while neuron 4's spike event is pending.
        do_reset();
        m_dt = 16'h0100;
        for (int n = 0; n < N; n++) cur_tab[n] = (n == 4) ? 16'h3200 : 16'h1000;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dt_tau = 16'h0100;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.spk_ready = 1'b0;
        waited = 0;
        while (!bus.spk_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("mid_emit_reached", 32'(bus.spk_valid), 1);
        chk("mid_emit_idx", 32'(bus.spk_idx), 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("mid_rst");
        rst = 1'b0;
        bus.spk_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_spk_valid", 32'(bus.spk_valid), 0);
        chk("post_rst_busy", 32'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
